// File: rtl/mix_state_signature.sv
// mix_state_signature: takes a snapshot of NWORDS state words over a
// valid/ready handshake, folds them one word per cycle into a running
// signature, and presents the signature plus a saturating snapshot count
// over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   in_valid/in_ready snapshot handshake (ready only while idle)
//   in_data           packed snapshot, word i at [i*WIDTH +: WIDTH]
//   clear             restart signature/count; honoured only while idle
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_sig           signature after the latest completed snapshot
//   out_count         number of snapshots folded, saturating at 16'hFFFF
module mix_state_signature #(
    parameter int unsigned     WIDTH  = 32,
    parameter int unsigned     NWORDS = 8,
    parameter logic [WIDTH-1:0] SEED  = 32'h0000_0001,
    parameter logic [WIDTH-1:0] K     = 32'h9E37_79B9,
    parameter int unsigned     ROT    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NWORDS*WIDTH-1:0]  in_data,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sig,
    output logic [15:0]              out_count
);

    localparam int unsigned IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned DW   = NWORDS * WIDTH;
    localparam int unsigned CNTW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sig_q, sig_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [DW-1:0]     cap_q, cap_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [WIDTH-1:0]  cur_word;
    logic [WIDTH-1:0]  rot_sig;
    logic [WIDTH-1:0]  fold_sig;

    // Select the captured word addressed by idx without a variable part-select.
    always_comb begin
        cur_word = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_word = cap_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // One fold step: rotate, mix in the word, add the constant (mod 2^WIDTH).
    always_comb begin
        rot_sig  = (sig_q << ROT) | (sig_q >> (WIDTH - ROT));
        fold_sig = (rot_sig ^ cur_word) + K;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        idx_d   = idx_q;
        count_d = count_q;
        cap_d   = cap_q;

        unique case (state_q)
            IDLE: begin
                // Clear and accept may coincide; folding then starts from SEED.
                if (clear) begin
                    sig_d   = SEED;
                    count_d = '0;
                end
                if (in_valid) begin
                    cap_d   = in_data;
                    idx_d   = '0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                sig_d = fold_sig;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDXW'(NWORDS - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                    if (count_q != {CNTW{1'b1}}) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sig_q       <= SEED;
            idx_q       <= '0;
            count_q     <= '0;
            cap_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            cap_q       <= cap_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sig   = sig_q;
    assign out_count = count_q;

endmodule
